// File: rtl/fpu_pkg.sv
// Shared constants, width helpers and the unpacked-operand view for the FP adder front end.
package fpu_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  function automatic int unsigned fp_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  // carry + hidden + fraction + 7 extension bits (LSB doubles as sticky)
  function automatic int unsigned out_w(input int unsigned man_w);
    return man_w + 9;
  endfunction

  localparam int unsigned FP_W_DEF  = fp_w(EXP_W_DEF, MAN_W_DEF);
  localparam int unsigned OUT_W_DEF = out_w(MAN_W_DEF);

  localparam logic [FP_W_DEF-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
    logic                 hidden;
  } fp_unpacked_t;

endpackage

// File: rtl/fpu_align_sticky.sv
// Saturating right shift of the smaller significand; every bit shifted out is ORed into the LSB.
module fpu_align_sticky #(
  parameter int unsigned W    = 32,
  parameter int unsigned SH_W = 8
) (
  input  logic [W-1:0]    data_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    data_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         lost;

  always_comb begin
    shifted   = '0;
    lost_mask = '1;
    if (32'(shamt_i) < W) begin
      shifted   = data_i >> shamt_i;
      lost_mask = ~({W{1'b1}} << shamt_i);
    end
    lost   = |(data_i & lost_mask);
    data_o = {shifted[W-1:1], shifted[0] | lost};
  end

endmodule

// File: rtl/fpu_add_pipe.sv
// Two-stage stallable FP add/sub front end: swap/compare/special detect, then align and add.
// Produces an un-normalised sum for the shared normalise/round stage.
module fpu_add_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 5,
  localparam int unsigned FP_W  = fp_w(EXP_W, MAN_W),
  localparam int unsigned OUT_W = out_w(MAN_W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_mantissa,
  output logic [EXP_W-1:0] out_exponent,
  output logic             out_sign,
  output logic             out_special,
  output logic [FP_W-1:0]  out_special_val,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [FP_W-1:0] QNAN_P   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [FP_W-1:0] NEG_ZERO = {1'b1, {(FP_W-1){1'b0}}};

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             hidden;
  } unp_t;

  typedef struct packed {
    logic             valid;
    logic             sign_l;
    logic [EXP_W-1:0] exp_l;
    logic             hid_l;
    logic [MAN_W-1:0] man_l;
    logic             hid_s;
    logic [MAN_W-1:0] man_s;
    logic [EXP_W-1:0] diff;
    logic             eff_sub;
    logic             neg_zero;
    logic             special;
    logic [FP_W-1:0]  special_val;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [OUT_W-1:0] mant;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             special;
    logic [FP_W-1:0]  special_val;
    logic [TAG_W-1:0] tag;
  } s2_t;

  // Subnormals get exponent 1 and no hidden bit so the exponent difference stays uniform.
  function automatic unp_t unpack(input logic [FP_W-1:0] x);
    unp_t u;
    u.hidden = |x[FP_W-2 -: EXP_W];
    u.exp    = u.hidden ? x[FP_W-2 -: EXP_W] : EXP_W'(1);
    u.man    = x[MAN_W-1:0];
    return u;
  endfunction

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic rdy_q;
  logic s1_adv, s2_adv, accept;

  assign s2_adv   = !s2_q.valid || out_ready;
  assign s1_adv   = !s1_q.valid || s2_adv;
  assign in_ready = rdy_q && s1_adv;
  assign accept   = in_valid && in_ready;

  logic [FP_W-1:0] b_eff;
  logic            a_gt;
  unp_t            u_l, u_s;
  logic            a_inf, a_nan, b_inf, b_nan, eff_sub;

  // Stage 1: effective operand, magnitude swap, specials
  always_comb begin
    b_eff   = {in_b[FP_W-1] ^ in_sub, in_b[FP_W-2:0]};
    a_gt    = in_a[FP_W-2:0] > b_eff[FP_W-2:0];
    u_l     = unpack(a_gt ? in_a : b_eff);
    u_s     = unpack(a_gt ? b_eff : in_a);
    a_inf   = (&in_a[FP_W-2 -: EXP_W]) && !(|in_a[MAN_W-1:0]);
    a_nan   = (&in_a[FP_W-2 -: EXP_W]) && (|in_a[MAN_W-1:0]);
    b_inf   = (&b_eff[FP_W-2 -: EXP_W]) && !(|b_eff[MAN_W-1:0]);
    b_nan   = (&b_eff[FP_W-2 -: EXP_W]) && (|b_eff[MAN_W-1:0]);
    eff_sub = in_a[FP_W-1] ^ b_eff[FP_W-1];

    s1_d = s1_q;
    if (s1_adv) begin
      s1_d.valid = accept;
      if (accept) begin
        s1_d.sign_l      = a_gt ? in_a[FP_W-1] : b_eff[FP_W-1];
        s1_d.exp_l       = u_l.exp;
        s1_d.hid_l       = u_l.hidden;
        s1_d.man_l       = u_l.man;
        s1_d.hid_s       = u_s.hidden;
        s1_d.man_s       = u_s.man;
        s1_d.diff        = u_l.exp - u_s.exp;
        s1_d.eff_sub     = eff_sub;
        s1_d.neg_zero    = (in_a == NEG_ZERO) && (b_eff == NEG_ZERO);
        s1_d.special     = 1'b0;
        s1_d.special_val = '0;
        s1_d.tag         = in_tag;
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
          s1_d.special     = 1'b1;
          s1_d.special_val = QNAN_P;
        end else if (a_inf) begin
          s1_d.special     = 1'b1;
          s1_d.special_val = in_a;
        end else if (b_inf) begin
          s1_d.special     = 1'b1;
          s1_d.special_val = b_eff;
        end
      end
    end
  end

  logic [OUT_W-1:0] m_l, m_s, m_s_al, sum;

  assign m_l = {1'b0, s1_q.hid_l, s1_q.man_l, 7'b0};
  assign m_s = {1'b0, s1_q.hid_s, s1_q.man_s, 7'b0};

  fpu_align_sticky #(
    .W    (OUT_W),
    .SH_W (EXP_W)
  ) u_align (
    .data_i  (m_s),
    .shamt_i (s1_q.diff),
    .data_o  (m_s_al)
  );

  // Stage 2: add/subtract aligned significands; the swap keeps the subtraction non-negative
  always_comb begin
    sum  = s1_q.eff_sub ? (m_l - m_s_al) : (m_l + m_s_al);
    s2_d = s2_q;
    if (s2_adv) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.tag = s1_q.tag;
        if (s1_q.special) begin
          s2_d.mant        = '0;
          s2_d.exp         = '0;
          s2_d.sign        = 1'b0;
          s2_d.special     = 1'b1;
          s2_d.special_val = s1_q.special_val;
        end else begin
          s2_d.mant        = sum;
          s2_d.exp         = s1_q.exp_l;
          s2_d.sign        = (sum == '0) ? s1_q.neg_zero : s1_q.sign_l;
          s2_d.special     = 1'b0;
          s2_d.special_val = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      rdy_q <= 1'b1;
    end
  end

  assign out_valid       = s2_q.valid;
  assign out_mantissa    = s2_q.mant;
  assign out_exponent    = s2_q.exp;
  assign out_sign        = s2_q.sign;
  assign out_special     = s2_q.special;
  assign out_special_val = s2_q.special_val;
  assign out_tag         = s2_q.tag;

endmodule
